// File: rtl/fetch_pkg.sv
// Shared fetch definitions: instruction geometry and the queued entry layout.
package fetch_pkg;

   localparam int INSTR_BYTES   = 4;
   localparam int PC_ALIGN_BITS = 2;
   localparam int PC_W          = 64;
   localparam int IW            = 32;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [IW-1:0]   instr;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with arbitrary depth, flush, and same-cycle push/pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop    = pop && (count != '0);
   assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_buffer.sv
// Prefetching fetch front end: issues sequential fetches into a credit-limited
// queue drained by decode; redirect flushes queue and in-flight fetch.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 64,
   parameter int                INSTR_W  = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]         imem_rdata,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_addr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INSTR_W-1:0]         out_instr,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic              pop;
   logic              push;
   logic [CW:0]       credit;
   logic [EW-1:0]     head;

   assign out_valid = (count != '0) && !redirect;
   assign pop       = out_valid && out_ready;

   // Slots already committed once this cycle's pop is accounted for.
   assign credit    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign imem_req  = !reset && !redirect && (credit < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc;
   assign push      = inflight && !redirect;

   assign {out_pc, out_instr} = head;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
      end else if (redirect) begin
         fetch_pc <= {redirect_addr[ADDR_W-1:PC_ALIGN_BITS],
                      {PC_ALIGN_BITS{1'b0}}};
         inflight <= 1'b0;
      end else if (imem_req) begin
         fetch_pc    <= fetch_pc + ADDR_W'(INSTR_BYTES);
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         inflight <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect),
      .push      (push),
      .push_data ({inflight_pc, imem_rdata}),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Parametrised instruction-fetch front end with a prefetch queue. It issues sequential word fetches to a synchronous instruction memory and buffers the returned instructions with their PCs. Decode drains the queue through a valid/ready handshake. Unlike the fixed single-register fetch stage, it supports decode back-pressure (stall), a configurable buffer depth and width, and a redirect that flushes the queue and any in-flight fetch on a taken branch.

Parameters:
- ADDR_W, 64, PC / fetch-address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries; legal range 2..16, need not be a power of two.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch issued this cycle.
- imem_addr  out  ADDR_W  fetch address; meaningful when imem_req=1.
- imem_rdata  in  INSTR_W  instruction for the previous cycle's request; fixed 1-cycle latency.
- redirect  in  1  flush and restart fetch.
- redirect_addr  in  ADDR_W  new fetch PC; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  head PC.
- count  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - fetch_pc=RESET_PC, queue empty, inflight=0.
  - out_valid=0, count=0, imem_req=0, imem_addr=RESET_PC.
  - reset has priority over redirect and over every other event.
- State held: fetch_pc, inflight flag, inflight_pc, queue storage, read/write pointers, count.
- Issue rule (combinational): imem_req = !reset && !redirect && (count + inflight - pop) < DEPTH, where pop = out_valid && out_ready.
  - This deliberately creates a combinational path from out_ready to imem_req.
  - imem_addr = fetch_pc.
  - On issue, fetch_pc <= fetch_pc + 4 (wraps modulo 2^ADDR_W), inflight <= 1, inflight_pc <= fetch_pc.
  - With no issue, inflight <= 0.
- Response: when inflight=1 and redirect=0, {imem_rdata, inflight_pc} is pushed at the end of the cycle.
- Output timing: no bypass. A pushed entry becomes visible on out_* in the following cycle.
  - Fetch-to-out_valid latency is 2 cycles after the issue cycle.
- Pop: on out_valid && out_ready, the head advances at the end of the cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Stall: while out_ready=0, out_instr and out_pc stay stable.
  - Issue continues until count + inflight = DEPTH, then imem_req=0.
  - No overflow is possible; the bench asserts "push while count==DEPTH never occurs".
- Throughput: one instruction per cycle is sustained whenever out_ready=1 and DEPTH>=2.
- Redirect, cycle r:
  - out_valid is forced to 0, so no pop occurs.
  - imem_req=0.
  - Any imem_rdata arriving in cycle r is discarded.
  - At the end of cycle r: queue cleared (count=0, pointers=0), inflight=0, fetch_pc={redirect_addr[ADDR_W-1:2],2'b00}.
  - Cycle r+1: imem_req=1 at the new PC.
  - Cycle r+3: out_valid=1 with out_pc=redirect target.
- Back-to-back redirects: the last one wins; each redirect cycle repeats the flush.
- Reset mid-operation: the queue and in-flight fetch are discarded exactly as at power-up.
  - The response from a request issued before reset is dropped.
- Empty queue: out_valid=0; out_instr and out_pc are don't-care (hold last value).

Decomposition:
- Shared package `fetch_pkg`:
  - INSTR_BYTES=4.
  - PC_ALIGN_BITS=2.
  - Typedef `fetch_entry_t` as a packed struct {pc, instr}, parametrised through the package localparams.
- One natural sub-module, `sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, reset, flush, push, push_data, pop, head_data, count.
  - Supports non-power-of-two depth and simultaneous push/pop.
- The issue/credit/redirect logic stays in fetch_buffer.

Test Plan:
- Sequential fetch: reset deasserts at cycle 0 with RESET_PC=0 and out_ready=1; memory returns addr-derived data. Required: out_pc=0,4,8,12 in consecutive cycles starting at cycle 2, one per cycle, count<=1.
- Stall and fill: with DEPTH=4, hold out_ready=0 for 10 cycles. Required: exactly 4 imem_req pulses; count saturates at 4; out_pc stays 0. Then raise out_ready. Required: 0,4,8,12,16 delivered in order with no gaps or duplicates.
- Redirect with a full queue: count=3 and inflight=1, then redirect=1 with redirect_addr=0x100. Required: out_valid=0 in the redirect cycle; next cycle imem_addr=0x100; out_pc=0x100 two cycles later; no old PCs ever appear.
- Misaligned redirect and wrap: redirect_addr=0xFFFF_FFFF_FFFF_FFFE. Required: fetched PCs are 0xFFFF_FFFF_FFFF_FFFC, then 0x0, then 0x4.
- Reset mid-stream: assert reset while count=2 and inflight=1. Required: next cycle out_valid=0, count=0, imem_req=0; after release, the first out_pc equals RESET_PC.
- Random back-pressure (DEPTH=3, 1000 cycles, out_ready random at 50%) against a scoreboard. Required: the PC stream is strictly sequential between redirects, there are no overflow assertions, and DEPTH=2 with out_ready=1 sustains 1 instruction per cycle.
